// File: rtl/param_ring_rotator.sv
// param_ring_rotator: WIDTH-bit walking-pattern source with rotate-left,
// rotate-right, bounce and Johnson modes, step enable, parallel load and a
// one-cycle period-complete pulse (wrap).
// Optional macro ROT_PRESCALE_EN: an 8-bit prescaler so that only every
// DIV-th enabled cycle becomes a step.
module param_ring_rotator #(
    parameter int unsigned WIDTH = 4,
    parameter logic [31:0] INIT  = 32'd1,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             dir
);

    localparam int unsigned CW = $clog2(2 * WIDTH) + 1;
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
    localparam logic [CW-1:0] P_ROT = CW'(WIDTH);
    localparam logic [CW-1:0] P_BNC = CW'(2 * WIDTH - 2);
    localparam logic [CW-1:0] P_JOH = CW'(2 * WIDTH);

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_BNC = 2'b10;

    // Out-of-range parameters are rejected at elaboration
    if (WIDTH < 2 || WIDTH > 32 || DIV < 1 || DIV > 255) begin : g_bad_param
        $error("param_ring_rotator: WIDTH or DIV out of range");
    end

    logic [1:0]       mode_q;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [CW-1:0]    period;
    logic [WIDTH-1:0] out_n;
    logic             dir_n;
    logic             wrap_n;
    logic             step;
`ifdef ROT_PRESCALE_EN
    logic [7:0]       presc;
    logic [7:0]       presc_n;
`endif

    // Period length of the currently selected mode
    always_comb begin
        period = P_ROT;
        if (mode == MODE_BNC) begin
            period = P_BNC;
        end else if (mode == 2'b11) begin
            period = P_JOH;
        end
    end

    // Next-state: load beats mode change beats step beats hold
    always_comb begin
        out_n  = out;
        dir_n  = dir;
        cnt_n  = cnt;
        wrap_n = 1'b0;
        step   = 1'b0;
`ifdef ROT_PRESCALE_EN
        presc_n = presc;
`endif
        if (load) begin
            out_n = load_val;
            dir_n = 1'b0;
            cnt_n = '0;
`ifdef ROT_PRESCALE_EN
            presc_n = '0;
`endif
        end else if (mode != mode_q) begin
            // A mode switch restarts the sequence without moving the pattern
            dir_n = 1'b0;
            cnt_n = '0;
`ifdef ROT_PRESCALE_EN
            presc_n = '0;
`endif
        end else if (en) begin
`ifdef ROT_PRESCALE_EN
            if (presc == 8'(DIV - 1)) begin
                step    = 1'b1;
                presc_n = '0;
            end else begin
                presc_n = presc + 8'd1;
            end
`else
            step = 1'b1;
`endif
        end

        if (step) begin
            case (mode)
                MODE_ROL: out_n = {out[WIDTH-2:0], out[WIDTH-1]};
                MODE_ROR: out_n = {out[0], out[WIDTH-1:1]};
                MODE_BNC: begin
                    // Reverse at the end bit in the current direction
                    if (!dir) begin
                        if (out[WIDTH-1]) begin
                            dir_n = 1'b1;
                            out_n = {1'b0, out[WIDTH-1:1]};
                        end else begin
                            out_n = {out[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (out[0]) begin
                            dir_n = 1'b0;
                            out_n = {out[WIDTH-2:0], 1'b0};
                        end else begin
                            out_n = {1'b0, out[WIDTH-1:1]};
                        end
                    end
                end
                default: out_n = {out[WIDTH-2:0], ~out[WIDTH-1]};
            endcase
            if (cnt == period - CW'(1)) begin
                cnt_n  = '0;
                wrap_n = 1'b1;
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out    <= INIT_V;
            dir    <= 1'b0;
            wrap   <= 1'b0;
            cnt    <= '0;
            mode_q <= 2'b00;
        end else begin
            out    <= out_n;
            dir    <= dir_n;
            wrap   <= wrap_n;
            cnt    <= cnt_n;
            mode_q <= mode;
        end
    end

`ifdef ROT_PRESCALE_EN
    // Prescaler register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else begin
            presc <= presc_n;
        end
    end
`endif

endmodule

// File: tb/tb_param_ring_rotator.sv
// Self-checking bench for param_ring_rotator (WIDTH=4, INIT=1).
// Expected out/wrap/dir triples are queued as stimulus is planned and
// popped one per clock after the active edge.
module tb_param_ring_rotator;

    localparam int unsigned W = 4;
`ifdef ROT_PRESCALE_EN
    localparam int unsigned DIV_P = 3;
`else
    localparam int unsigned DIV_P = 1;
`endif

    typedef struct packed {
        logic [W-1:0] o;
        logic         w;
        logic         d;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] out;
    logic         wrap;
    logic         dir;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;

    param_ring_rotator #(.WIDTH(W), .INIT(32'd1), .DIV(DIV_P)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
        .load_val(load_val), .out(out), .wrap(wrap), .dir(dir)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; mode = 2'b00; load = 1'b0;
        sb.push_back('{o: 4'b0001, w: 1'b0, d: 1'b0});
        cyc();
        e = sb.pop_front();
        n_chk++;
        if (out !== e.o || wrap !== e.w || dir !== e.d)
            $display("FAIL reset: got out=%b wrap=%b dir=%b want out=%b wrap=%b dir=%b", out, wrap, dir, e.o, e.w, e.d);
        else n_pass++;
        #2 reset = 1'b0;
        en = 1'b0;
    endtask

    task automatic test_rotate_left();
        logic [W-1:0] seq [5];
        logic         wr  [5];
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        wr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        mode = 2'b00; en = 1'b1;
        for (int i = 0; i < 5; i++) sb.push_back('{o: seq[i], w: wr[i], d: 1'b0});
        for (int i = 0; i < 5; i++) begin
            cyc();
            e = sb.pop_front();
            n_chk++;
            if (out !== e.o || wrap !== e.w || dir !== e.d)
                $display("FAIL rol step %0d: got out=%b wrap=%b dir=%b want out=%b wrap=%b dir=%b", i, out, wrap, dir, e.o, e.w, e.d);
            else n_pass++;
        end
        en = 1'b0;
    endtask

    task automatic test_bounce();
        logic [W-1:0] seq [8];
        logic         wr  [8];
        logic         dr  [8];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        dr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) sb.push_back('{o: seq[i], w: wr[i], d: dr[i]});
        for (int i = 0; i < 8; i++) begin
            // first cycle loads 0001 while switching to bounce, with en high
            load = (i == 0); load_val = 4'b0001; mode = 2'b10; en = 1'b1;
            cyc();
            e = sb.pop_front();
            n_chk++;
            if (out !== e.o || wrap !== e.w || dir !== e.d)
                $display("FAIL bounce cyc %0d: got out=%b wrap=%b dir=%b want out=%b wrap=%b dir=%b", i, out, wrap, dir, e.o, e.w, e.d);
            else n_pass++;
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_bounce_zero();
        for (int i = 0; i < 7; i++) sb.push_back('{o: 4'b0000, w: (i == 6), d: 1'b0});
        for (int i = 0; i < 7; i++) begin
            load = (i == 0); load_val = 4'b0000; mode = 2'b10; en = 1'b1;
            cyc();
            e = sb.pop_front();
            n_chk++;
            if (out !== e.o || wrap !== e.w || dir !== e.d)
                $display("FAIL bounce_zero cyc %0d: got out=%b wrap=%b dir=%b want out=%b wrap=%b dir=%b", i, out, wrap, dir, e.o, e.w, e.d);
            else n_pass++;
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_johnson();
        logic [W-1:0] seq [9];
        seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        for (int i = 0; i < 9; i++) sb.push_back('{o: seq[i], w: (i == 8), d: 1'b0});
        for (int i = 0; i < 9; i++) begin
            load = (i == 0); load_val = 4'b0000; mode = 2'b11; en = 1'b1;
            cyc();
            e = sb.pop_front();
            n_chk++;
            if (out !== e.o || wrap !== e.w || dir !== e.d)
                $display("FAIL johnson cyc %0d: got out=%b wrap=%b dir=%b want out=%b wrap=%b dir=%b", i, out, wrap, dir, e.o, e.w, e.d);
            else n_pass++;
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_mode_change();
        logic [W-1:0] seq [7];
        logic [1:0]   md  [7];
        seq = '{4'b0010, 4'b0100, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
        md  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        mode = 2'b00;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        for (int i = 0; i < 7; i++) sb.push_back('{o: seq[i], w: (i == 6), d: 1'b0});
        for (int i = 0; i < 7; i++) begin
            mode = md[i]; en = 1'b1;
            cyc();
            e = sb.pop_front();
            n_chk++;
            if (out !== e.o || wrap !== e.w || dir !== e.d)
                $display("FAIL mode_change cyc %0d: got out=%b wrap=%b dir=%b want out=%b wrap=%b dir=%b", i, out, wrap, dir, e.o, e.w, e.d);
            else n_pass++;
        end
        // asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (out !== 4'b0001 || wrap !== 1'b0 || dir !== 1'b0)
            $display("FAIL async_reset: got out=%b wrap=%b dir=%b want out=0001 wrap=0 dir=0", out, wrap, dir);
        else n_pass++;
        cyc();
        n_chk++;
        if (out !== 4'b0001 || wrap !== 1'b0)
            $display("FAIL reset_hold: got out=%b wrap=%b want out=0001 wrap=0", out, wrap);
        else n_pass++;
        #2 reset = 1'b0;
        en = 1'b0; mode = 2'b00;
    endtask

    task automatic test_load_hold();
        for (int i = 0; i < 4; i++) sb.push_back('{o: 4'b1010, w: 1'b0, d: 1'b0});
        for (int i = 0; i < 4; i++) begin
            load = (i == 0); load_val = 4'b1010; en = (i == 0); mode = 2'b00;
            cyc();
            e = sb.pop_front();
            n_chk++;
            if (out !== e.o || wrap !== e.w || dir !== e.d)
                $display("FAIL load_hold cyc %0d: got out=%b wrap=%b dir=%b want out=%b wrap=%b dir=%b", i, out, wrap, dir, e.o, e.w, e.d);
            else n_pass++;
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_random_rotate();
        logic [W-1:0] m_out;
        int           m_cnt;
        logic [W-1:0] lv;
        logic         ens [40];
        lv = 4'b0110;
        m_out = lv; m_cnt = 0;
        sb.push_back('{o: m_out, w: 1'b0, d: 1'b0});
        for (int i = 0; i < 40; i++) begin
            logic wexp;
            ens[i] = 1'($urandom_range(0, 1));
            wexp = 1'b0;
            if (ens[i]) begin
                m_out = {m_out[0], m_out[W-1:1]};
                if (m_cnt == W - 1) begin m_cnt = 0; wexp = 1'b1; end
                else m_cnt++;
            end
            sb.push_back('{o: m_out, w: wexp, d: 1'b0});
        end
        for (int i = 0; i < 41; i++) begin
            load = (i == 0); load_val = lv; mode = 2'b01;
            en = (i == 0) ? 1'b1 : ens[i-1];
            cyc();
            e = sb.pop_front();
            n_chk++;
            if (out !== e.o || wrap !== e.w || dir !== e.d)
                $display("FAIL random_ror cyc %0d: got out=%b wrap=%b dir=%b want out=%b wrap=%b dir=%b", i, out, wrap, dir, e.o, e.w, e.d);
            else n_pass++;
        end
        load = 1'b0; en = 1'b0;
    endtask

`ifdef ROT_PRESCALE_EN
    task automatic test_prescale();
        logic [W-1:0] seq [9];
        seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
        mode = 2'b00;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        for (int i = 0; i < 9; i++) sb.push_back('{o: seq[i], w: 1'b0, d: 1'b0});
        for (int i = 0; i < 9; i++) begin
            en = 1'b1;
            cyc();
            e = sb.pop_front();
            n_chk++;
            if (out !== e.o || wrap !== e.w || dir !== e.d)
                $display("FAIL prescale cyc %0d: got out=%b wrap=%b dir=%b want out=%b wrap=%b dir=%b", i, out, wrap, dir, e.o, e.w, e.d);
            else n_pass++;
        end
        en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef ROT_PRESCALE_EN
        test_prescale();
`else
        test_rotate_left();
        test_bounce();
        test_bounce_zero();
        test_johnson();
        test_mode_change();
        test_load_hold();
        test_random_rotate();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/param_ring_rotator.md
Name: param_ring_rotator

Overview:
- Parametrised successor to the fixed 4-bit free-running rotator.
- Generates a WIDTH-bit walking pattern with selectable mode:
  - rotate left
  - rotate right
  - bounce (ping-pong)
  - Johnson (twisted ring)
- Adds step enable, parallel load and a period-complete pulse.
- Sits as a pattern/sequence source driving display or test logic; one clock domain.

Parameters:
- WIDTH, 4, pattern width in bits; legal range 2..32.
- INIT, 1, reset and default seed value; WIDTH bits, zero-extended/truncated.
- DIV, 1, prescaler ratio (used only with ROT_PRESCALE_EN); legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  step enable; one step per enabled cycle.
- mode  input  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 Johnson.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- out  output  WIDTH  current pattern, registered.
- wrap  output  1  one-cycle pulse when a full period completes.
- dir  output  1  bounce direction; 0=left, 1=right; registered.

Behaviour:
- Reset (async, active-high): out=INIT, dir=0, wrap=0, step count=0, mode_q=00, prescaler=0. Outputs hold while reset is high.
- Priority per rising edge: load > en > hold.
- Load:
  - out<=load_val, dir<=0, count<=0, wrap<=0, prescaler<=0.
  - Load ignores en.
- Step (en=1, no load), out updates at the next edge (latency 1):
  - 00: rotate left; out[0] receives the old out[WIDTH-1].
  - 01: rotate right; out[WIDTH-1] receives the old out[0].
  - 10 bounce, zero-fill shifts:
    - dir=0: if out[WIDTH-1]=1, then dir<=1 and shift right; else shift left.
    - dir=1: if out[0]=1, then dir<=0 and shift left; else shift right.
    - out=0 stays 0 and dir still toggles per the rule above (no toggle since no end bit set).
  - 11 Johnson: shift left; out[0] receives ~old out[WIDTH-1].
- Period P per mode: rotate=WIDTH, bounce=2*WIDTH-2, Johnson=2*WIDTH.
- Step counter:
  - Width ceil(log2(2*WIDTH))+1; counts steps.
  - On a step where count==P-1: count<=0 and wrap<=1 for exactly one cycle, coincident with the new out.
  - Otherwise wrap<=0.
- Mode change:
  - mode is registered into mode_q each cycle.
  - When mode!=mode_q: count<=0, dir<=0, wrap<=0; out is unchanged that cycle (no step even if en=1).
  - Stepping in the new mode begins on the following enabled cycle.
- en low: out, dir and count hold; wrap<=0.
- Reset mid-operation: immediate return to reset values regardless of clk.

Optional Feature:
- Macro: ROT_PRESCALE_EN.
- Defined:
  - An 8-bit prescaler counts enabled cycles.
  - A step occurs only on the enabled cycle where prescaler==DIV-1; prescaler then returns to 0.
  - Disabled cycles hold the prescaler.
  - Load and mode change clear the prescaler.
  - DIV=1 is identical to the undefined behaviour.
- Undefined: no prescaler logic; every enabled cycle is a step; DIV is ignored.

Test Plan (WIDTH=4, INIT=1, macro undefined unless stated):
- Reset then mode=00, en=1 for 5 cycles -> out 0010,0100,1000,0001,0010; wrap high only with the 4th value (0001).
- Load 0001, mode=10, en=1 for 7 cycles -> out 0010,0100,1000,0100,0010,0001,0010; dir=1 after the 1000→0100 step; wrap with the 6th value (0001).
- Load 0000, mode=11, en=1 for 8 cycles -> 0001,0011,0111,1111,1110,1100,1000,0000; wrap with 0000.
- Mode 00 stepping, switch mode to 01 with en=1 -> out holds one cycle, count cleared, then rotates right; assert reset mid-cycle -> out=0001 immediately.
- load=1 with en=1 and load_val=1010 -> out=1010 next edge, no step; then en=0 for 3 cycles -> out and wrap stay 1010/0.
- ROT_PRESCALE_EN defined, DIV=3, mode=00, en=1 for 9 cycles -> out steps only on cycles 3, 6 and 9: 0010,0100,1000.
